// File: rtl/bus_pkg.sv
// Shared region map, FSM encoding and default wait states for the data-bus arbiter.
package bus_pkg;
  localparam logic [3:0] REG_ROM  = 4'h0;
  localparam logic [3:0] REG_RAM  = 4'h1;
  localparam logic [3:0] REG_UART = 4'h2;

  localparam int DEF_ROM_WAIT  = 0;
  localparam int DEF_RAM_WAIT  = 1;
  localparam int DEF_UART_WAIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/dbus_arbiter_if.sv
// Two-master request/response bundle plus the system-bus side of the arbiter.
interface dbus_arbiter_if;
  logic        m0_req, m0_wen, m0_ready, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wen, m1_ready, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wen;
  logic        busy, gnt_id;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_wen,
    output m0_rdata, m0_ready, m0_err,
    input  m1_req, m1_addr, m1_wdata, m1_wen,
    output m1_rdata, m1_ready, m1_err,
    output bus_addr, bus_wdata, bus_wen,
    input  bus_rdata,
    output busy, gnt_id
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_wen,
    input  m0_rdata, m0_ready, m0_err,
    output m1_req, m1_addr, m1_wdata, m1_wen,
    input  m1_rdata, m1_ready, m1_err,
    input  bus_addr, bus_wdata, bus_wen,
    output bus_rdata,
    input  busy, gnt_id
  );
endinterface

// File: rtl/dbus_arbiter_rr_arb2.sv
// Combinational two-way request picker; prio breaks the tie when both request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_id,
  output logic       gnt_valid
);
  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? prio : req[1];
  end
endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one wait-stated system bus between two masters.
module dbus_arbiter
  import bus_pkg::*;
#(
  parameter int ROM_WAIT  = DEF_ROM_WAIT,
  parameter int RAM_WAIT  = DEF_RAM_WAIT,
  parameter int UART_WAIT = DEF_UART_WAIT
) (
  input  logic           clk,
  input  logic           reset,
  dbus_arbiter_if.slave  dif
);
  state_e      state_q, state_d;
  logic        prio_q, prio_d, gnt_q, gnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        wen_q, wen_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        arb_id, arb_vld;
  logic [31:0] sel_addr;

  rr_arb2 u_arb (
    .req       ({dif.m1_req, dif.m0_req}),
    .prio      (prio_q),
    .gnt_id    (arb_id),
    .gnt_valid (arb_vld)
  );

  assign sel_addr = arb_id ? dif.m1_addr : dif.m0_addr;

  // {err, wait}: unmapped regions complete immediately and flag an error
  function automatic logic [4:0] decode(input logic [3:0] rgn);
    case (rgn)
      REG_ROM:  return {1'b0, 4'(ROM_WAIT)};
      REG_RAM:  return {1'b0, 4'(RAM_WAIT)};
      REG_UART: return {1'b0, 4'(UART_WAIT)};
      default:  return {1'b1, 4'd0};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (arb_vld) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: if (arb_vld) begin
        gnt_d          = arb_id;
        addr_d         = sel_addr;
        wdata_d        = arb_id ? dif.m1_wdata : dif.m0_wdata;
        wen_d          = arb_id ? dif.m1_wen   : dif.m0_wen;
        {err_d, cnt_d} = decode(sel_addr[31:28]);
      end
      ST_ACCESS: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else if (gnt_q)    rdata1_d = err_q ? 32'd0 : dif.bus_rdata;
        else               rdata0_d = err_q ? 32'd0 : dif.bus_rdata;
      end
      ST_RESP: prio_d = ~gnt_q;
      default: ;
    endcase
  end

  always_comb begin
    dif.busy      = (state_q != ST_IDLE);
    dif.gnt_id    = gnt_q;
    dif.bus_addr  = addr_q;
    dif.bus_wdata = wdata_q;
    dif.bus_wen   = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && wen_q && !err_q;
    dif.m0_ready  = (state_q == ST_RESP) && !gnt_q;
    dif.m1_ready  = (state_q == ST_RESP) && gnt_q;
    dif.m0_err    = dif.m0_ready && err_q;
    dif.m1_err    = dif.m1_ready && err_q;
    dif.m0_rdata  = rdata0_q;
    dif.m1_rdata  = rdata1_q;
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed vector table, corner sequences, random run vs transaction model.
module tb_dbus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dbus_arbiter_if dif();
  dbus_arbiter u_dut (.clk(clk), .reset(reset), .dif(dif));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          m;
    logic [31:0] addr, wdata;
    logic        wen;
    logic [31:0] rdata;
    int          lat;
    logic        err;
    logic [31:0] exp_rd;
    int          wens;
    int          wen_at;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_m(input bit m, input logic req, input logic [31:0] a, input logic [31:0] wd,
                       input logic we);
    if (m) begin
      dif.m1_req = req; dif.m1_addr = a; dif.m1_wdata = wd; dif.m1_wen = we;
    end else begin
      dif.m0_req = req; dif.m0_addr = a; dif.m0_wdata = wd; dif.m0_wen = we;
    end
  endtask

  function automatic logic get_rdy(input bit m);
    return m ? dif.m1_ready : dif.m0_ready;
  endfunction
  function automatic logic get_err(input bit m);
    return m ? dif.m1_err : dif.m0_err;
  endfunction
  function automatic logic [31:0] get_rd(input bit m);
    return m ? dif.m1_rdata : dif.m0_rdata;
  endfunction

  // Region table: wait cycles per mapped region, -1 for unmapped
  function automatic int wait_of(input logic [3:0] nib);
    case (nib)
      4'h0: return 0;
      4'h1: return 1;
      4'h2: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    dif.bus_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat, wens, wen_at, other;
    logic err;
    logic [31:0] wd_seen;
    bit done;
    lat = 0; wens = 0; wen_at = -1; other = 0; err = 0; done = 0; wd_seen = '0;
    set_m(v.m, 1, v.addr, v.wdata, v.wen);
    dif.bus_rdata = v.rdata;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (dif.bus_wen) begin wens++; wen_at = lat; wd_seen = dif.bus_wdata; end
      if (get_rdy(!v.m)) other++;
      if (get_rdy(v.m)) begin
        done = 1;
        err = get_err(v.m);
        set_m(v.m, 0, 0, 0, 0);
      end
    end
    if (!done) set_m(v.m, 0, 0, 0, 0);
    chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(v.lat));
    chk($sformatf("vec%0d_err", i), 64'(err), 64'(v.err));
    chk($sformatf("vec%0d_rdata", i), 64'(get_rd(v.m)), 64'(v.exp_rd));
    chk($sformatf("vec%0d_wen_count", i), 64'(wens), 64'(v.wens));
    chk($sformatf("vec%0d_other_ready", i), 64'(other), 64'd0);
    if (v.wens > 0) begin
      chk($sformatf("vec%0d_wen_cycle", i), 64'(wen_at), 64'(v.wen_at));
      chk($sformatf("vec%0d_wdata", i), 64'(wd_seen), 64'(v.wdata));
    end
    chk($sformatf("vec%0d_addr_held", i), 64'(dif.bus_addr), 64'(v.addr));
    tick();
  endtask

  task automatic seq_alternate();
    bit order[$];
    int c;
    do_reset();
    set_m(0, 1, 32'h1000_0000, 0, 0);
    set_m(1, 1, 32'h1000_0100, 0, 0);
    c = 0;
    while (order.size() < 4 && c < 40) begin
      tick(); c++;
      if (dif.m0_ready) order.push_back(1'b0);
      if (dif.m1_ready) order.push_back(1'b1);
    end
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    chk("alt_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("alt_grant%0d", i), 64'(order[i]), 64'(i % 2));
    tick(); tick();
  endtask

  task automatic seq_reset_mid();
    int bad;
    do_reset();
    set_m(0, 1, 32'h2000_0000, 32'h55, 1);
    tick(); tick();
    chk("rstmid_busy_before", 64'(dif.busy), 64'd1);
    reset = 1'b1;
    set_m(0, 0, 0, 0, 0);
    tick();
    chk("rstmid_ctl", {57'd0, dif.busy, dif.bus_wen, dif.m0_ready, dif.m0_err, dif.m1_ready,
                       dif.m1_err, dif.gnt_id}, 64'd0);
    chk("rstmid_bus", {dif.bus_addr, dif.bus_wdata}, 64'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dif.bus_wen || dif.m0_ready || dif.busy) bad++;
    end
    chk("rstmid_quiet_after", 64'(bad), 64'd0);
  endtask

  task automatic seq_blocked();
    int c, r0, r1;
    logic g3, g7;
    do_reset();
    set_m(0, 1, 32'h2000_0010, 0, 0);
    c = 0; r0 = -1; r1 = -1; g3 = 1'bx; g7 = 1'bx;
    while ((r0 < 0 || r1 < 0) && c < 20) begin
      tick(); c++;
      if (c == 1) set_m(1, 1, 32'h1000_0020, 0, 0);
      if (c == 3) g3 = dif.gnt_id;
      if (c == 7) g7 = dif.gnt_id;
      if (dif.m0_ready) begin r0 = c; set_m(0, 0, 0, 0, 0); end
      if (dif.m1_ready) begin r1 = c; set_m(1, 0, 0, 0, 0); end
    end
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    chk("blk_m0_ready_cycle", 64'(r0), 64'd5);
    chk("blk_m1_ready_cycle", 64'(r1), 64'd9);
    chk("blk_gnt_during_m0", 64'(g3), 64'd0);
    chk("blk_gnt_during_m1", 64'(g7), 64'd1);
    tick();
  endtask

  // Transaction-level model: the bus is free from next_idle on; a grant at cycle k with
  // wait W strobes/captures at k+W+1, responds at k+W+2 and frees the bus at k+W+3.
  task automatic run_random(input int cycles);
    bit pend[2];
    logic [31:0] pa[2], pw[2], exp_rd[2];
    logic pwe[2];
    int next_idle, g_cyc, gw, rdy, fin, w;
    bit active, g_id, g_err, g_wen, prio;
    logic [31:0] g_addr, g_wdata, cap;
    logic [3:0] nib;
    logic e_busy, e_r0, e_r1, e_wen;
    do_reset();
    pend = '{0, 0}; exp_rd = '{32'd0, 32'd0}; pa = '{32'd0, 32'd0}; pw = '{32'd0, 32'd0};
    pwe = '{1'b0, 1'b0};
    next_idle = 0; g_cyc = -100; gw = 0; active = 0; g_id = 0; g_err = 0; g_wen = 0; prio = 0;
    g_addr = '0; g_wdata = '0; cap = '0;
    for (int k = 0; k < cycles; k++) begin
      rdy = g_cyc + gw + 2;
      fin = g_cyc + gw + 1;
      if (active && k == rdy) exp_rd[g_id] = cap;
      e_busy = active && k > g_cyc && k <= rdy;
      e_r0 = active && k == rdy && !g_id;
      e_r1 = active && k == rdy && g_id;
      e_wen = active && k == fin && g_wen && !g_err;
      chk("rnd_ctl", {57'd0, dif.m0_ready, dif.m0_err, dif.m1_ready, dif.m1_err, dif.bus_wen,
                      dif.busy, dif.gnt_id},
          {57'd0, e_r0, e_r0 && g_err, e_r1, e_r1 && g_err, e_wen, e_busy, g_id});
      chk("rnd_rdata", {dif.m0_rdata, dif.m1_rdata}, {exp_rd[0], exp_rd[1]});
      if (e_busy) chk("rnd_bus", {dif.bus_addr, dif.bus_wdata}, {g_addr, g_wdata});
      for (int m = 0; m < 2; m++) begin
        if (active && k == rdy && g_id == m[0]) pend[m] = 0;
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          nib = 4'($urandom_range(0, 5));
          if (nib > 4'd2) nib = 4'($urandom_range(3, 15));
          pend[m] = 1;
          pa[m] = {nib, 28'($urandom())};
          pw[m] = $urandom();
          pwe[m] = 1'($urandom_range(0, 1));
        end
        set_m(m[0], pend[m], pa[m], pw[m], pwe[m]);
      end
      dif.bus_rdata = $urandom();
      if (active && k == fin) cap = g_err ? 32'd0 : dif.bus_rdata;
      if (k >= next_idle && (pend[0] || pend[1])) begin
        g_id = (pend[0] && pend[1]) ? prio : pend[1];
        prio = !g_id;
        g_addr = pa[g_id]; g_wdata = pw[g_id]; g_wen = pwe[g_id];
        w = wait_of(g_addr[31:28]);
        g_err = (w < 0);
        gw = g_err ? 0 : w;
        g_cyc = k;
        next_idle = k + gw + 3;
        active = 1;
      end
      tick();
    end
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{m:1'b0, addr:32'h1000_0004, wdata:32'h0, wen:1'b0, rdata:32'hDEAD_BEEF,
                lat:3, err:1'b0, exp_rd:32'hDEAD_BEEF, wens:0, wen_at:0};
    vecs[1] = '{m:1'b1, addr:32'h2000_0000, wdata:32'h41, wen:1'b1, rdata:32'h1234_5678,
                lat:5, err:1'b0, exp_rd:32'h1234_5678, wens:1, wen_at:4};
    vecs[2] = '{m:1'b0, addr:32'h5000_0000, wdata:32'h0, wen:1'b0, rdata:32'hFFFF_FFFF,
                lat:2, err:1'b1, exp_rd:32'h0, wens:0, wen_at:0};
    vecs[3] = '{m:1'b1, addr:32'h0000_0010, wdata:32'h0, wen:1'b0, rdata:32'hCAFE_0001,
                lat:2, err:1'b0, exp_rd:32'hCAFE_0001, wens:0, wen_at:0};
    vecs[4] = '{m:1'b0, addr:32'h1000_0008, wdata:32'hA5A5_0000, wen:1'b1, rdata:32'h0BAD_F00D,
                lat:3, err:1'b0, exp_rd:32'h0BAD_F00D, wens:1, wen_at:2};
    vecs[5] = '{m:1'b1, addr:32'hF000_0000, wdata:32'h77, wen:1'b1, rdata:32'h1111_1111,
                lat:2, err:1'b1, exp_rd:32'h0, wens:0, wen_at:0};

    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    dif.bus_rdata = '0;
    reset = 1'b1;
    tick();
    chk("reset_ctl", {57'd0, dif.busy, dif.bus_wen, dif.m0_ready, dif.m0_err, dif.m1_ready,
                      dif.m1_err, dif.gnt_id}, 64'd0);
    chk("reset_bus", {dif.bus_addr, dif.bus_wdata}, 64'd0);
    chk("reset_rdata", {dif.m0_rdata, dif.m1_rdata}, 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
    seq_alternate();
    seq_reset_mid();
    seq_blocked();
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 0, extra wait cycles for region 4'h0 (ROM).
REQ-002 SHALL have parameter RAM_WAIT, default 1, extra wait cycles for region 4'h1 (RAM).
REQ-003 SHALL have parameter UART_WAIT, default 3, extra wait cycles for region 4'h2 (UART); all wait parameters are 0..15.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports m0_req in 1, m0_addr in 32, m0_wdata in 32, m0_wen in 1: master 0 (CPU data port) request.
REQ-007 SHALL have ports m0_rdata out 32, m0_ready out 1, m0_err out 1: master 0 response.
REQ-008 SHALL have ports m1_req, m1_addr, m1_wdata, m1_wen, m1_rdata, m1_ready, m1_err: master 1 (debug/loader), same widths and directions as master 0.
REQ-009 SHALL have ports bus_addr out 32, bus_wdata out 32, bus_wen out 1: to system bus CPU-side data inputs.
REQ-010 SHALL have port bus_rdata  in  32  read data returned by system bus.
REQ-011 SHALL have ports busy out 1 (state != IDLE) and gnt_id out 1 (master currently owning bus).

Function
REQ-012 SHALL implement states IDLE, ACCESS, RESP; IDLE->ACCESS on any req; ACCESS->RESP when wait counter == 0; RESP->IDLE unconditionally.
REQ-013 SHALL sample mX_req only in IDLE; requests in ACCESS/RESP are ignored until next IDLE.
REQ-014 SHALL, with one requester in IDLE, grant it; with both, grant the master indicated by priority pointer prio.
REQ-015 SHALL toggle prio to the non-granted master on every RESP cycle (round-robin), giving fairness under continuous dual requests.
REQ-016 SHALL, on grant, register granted addr/wdata/wen into bus_addr/bus_wdata/an internal wen latch, set gnt_id, and load counter from addr[31:28]: 0->ROM_WAIT, 1->RAM_WAIT, 2->UART_WAIT, other->0 with err flag set.
REQ-017 SHALL hold bus_addr/bus_wdata stable from the ACCESS entry through RESP.
REQ-018 SHALL decrement the counter each ACCESS cycle while nonzero.
REQ-019 SHALL assert bus_wen only in the final ACCESS cycle (counter == 0) and only if latched wen=1 and region is mapped: exactly one write strobe per write.
REQ-020 SHALL capture bus_rdata into the granted mX_rdata at the end of the final ACCESS cycle (unmapped: capture 0); mX_rdata holds until next grant to that master.
REQ-021 SHALL pulse granted mX_ready for exactly the RESP cycle; mX_err pulses in the same cycle for unmapped regions; non-granted master's ready/err stay 0.
REQ-022 SHALL yield latency: req sampled in IDLE at cycle N -> ready at cycle N+W+2 (W = region wait); minimum three-cycle issue interval per master.
REQ-023 Requester SHALL hold req/addr/wdata/wen until ready and deassert req in the ready cycle unless issuing another transaction; a req held high in IDLE starts a new transaction.

Reset
REQ-024 SHALL, on reset, enter IDLE, prio=0, gnt_id=0, counter=0, busy=0, bus_wen=0, bus_addr=0, bus_wdata=0, all ready/err=0, all rdata=0.
REQ-025 SHALL, on reset asserted mid-ACCESS or RESP, abort with no bus_wen and no ready pulse in the following cycle.

Structure
REQ-026 SHALL place region codes (ROM 4'h0, RAM 4'h1, UART 4'h2), state encoding and default wait values in shared package bus_pkg.
REQ-027 SHALL implement request selection as sub-module rr_arb2 (inputs req[1:0], prio; output gnt_id, gnt_valid), purely combinational; state/counter live in dbus_arbiter.

Verification
REQ-028 Single m0 read of 0x1000_0004, bus_rdata=0xDEAD_BEEF -> m0_ready at N+3, m0_rdata=0xDEAD_BEEF, bus_wen never 1.
REQ-029 m1 write 0x2000_0000 data 0x41 -> bus_wen high exactly one cycle (N+4), bus_wdata=0x41, m1_ready at N+5.
REQ-030 Both req continuous, RAM reads -> grants alternate m0,m1,m0,m1 starting with m0 after reset.
REQ-031 m0 read 0x5000_0000 -> m0_ready and m0_err at N+2, m0_rdata=0, bus_wen=0.
REQ-032 Reset asserted during UART write ACCESS (counter=2) -> next cycle IDLE, busy=0, no bus_wen, no ready.
REQ-033 m1 requests while m0 in ACCESS -> m1 not granted until the IDLE after m0_ready; m1 then granted.
